// File: rtl/meio_somador.sv
// Half adder leaf cell of the ULA adder chain: combinational {Cout,R} = A + B plus a
// one-stage registered copy with valid flag. Optional statistics counters: MEIO_SOMADOR_STATS_EN.
module meio_somador #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] R,
  output logic             Cout,
  output logic [WIDTH-1:0] R_q,
  output logic             Cout_q,
  output logic             out_valid
`ifdef MEIO_SOMADOR_STATS_EN
  ,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  logic [WIDTH:0] sum_s;

  // Widened unsigned add; the top bit is the carry-out.
  always_comb begin
    sum_s = {1'b0, A} + {1'b0, B};
  end

  assign R    = sum_s[WIDTH-1:0];
  assign Cout = sum_s[WIDTH];

  // Registered copy of the sum; holds its value when no valid operand is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_q       <= {WIDTH{1'b0}};
      Cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        R_q    <= sum_s[WIDTH-1:0];
        Cout_q <= sum_s[WIDTH];
      end else begin
        R_q    <= R_q;
        Cout_q <= Cout_q;
      end
    end
  end

`ifdef MEIO_SOMADOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating operation and carry counters; they stick at all ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt    <= {CNT_W{1'b0}};
      carry_cnt <= {CNT_W{1'b0}};
    end else begin
      if (in_valid && (op_cnt != CNT_MAX)) begin
        op_cnt <= op_cnt + CNT_ONE;
      end else begin
        op_cnt <= op_cnt;
      end
      if (in_valid && sum_s[WIDTH] && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + CNT_ONE;
      end else begin
        carry_cnt <= carry_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_meio_somador.sv
// Directed self-checking bench for meio_somador at WIDTH=1, 4 and 8, plus the
// statistics counters when MEIO_SOMADOR_STATS_EN is defined.
`timescale 1ns/1ps
module tb_meio_somador;

  int checks   = 0;
  int failures = 0;

  logic clk      = 1'b0;
  logic clk_en   = 1'b0;
  logic clk_idle = 1'b0;
  logic rst_n    = 1'b0;

  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       v1 = 1'b0;
  logic [0:0] r1, rq1;
  logic       c1, cq1, ov1;

  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic       v4 = 1'b0;
  logic [3:0] r4, rq4;
  logic       c4, cq4, ov4;

  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       v8 = 1'b0;
  logic [7:0] r8, rq8;
  logic       c8, cq8, ov8;

  always #5 if (clk_en) clk = ~clk;

`ifdef MEIO_SOMADOR_STATS_EN
  logic [15:0] opc1, cc1, opc4, cc4, opc8, cc8;
  logic [3:0]  as = 4'd0, bs = 4'd0;
  logic        vs = 1'b0;
  logic [3:0]  rs, rqs;
  logic        cs, cqs, ovs;
  logic [1:0]  opcs, ccs;
`endif

  meio_somador #(.WIDTH(1)) u1 (
    .clk(clk_idle), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(v1),
    .R(r1), .Cout(c1), .R_q(rq1), .Cout_q(cq1), .out_valid(ov1)
`ifdef MEIO_SOMADOR_STATS_EN
    , .op_cnt(opc1), .carry_cnt(cc1)
`endif
  );

  meio_somador #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .in_valid(v4),
    .R(r4), .Cout(c4), .R_q(rq4), .Cout_q(cq4), .out_valid(ov4)
`ifdef MEIO_SOMADOR_STATS_EN
    , .op_cnt(opc4), .carry_cnt(cc4)
`endif
  );

  meio_somador #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(v8),
    .R(r8), .Cout(c8), .R_q(rq8), .Cout_q(cq8), .out_valid(ov8)
`ifdef MEIO_SOMADOR_STATS_EN
    , .op_cnt(opc8), .carry_cnt(cc8)
`endif
  );

`ifdef MEIO_SOMADOR_STATS_EN
  meio_somador #(.WIDTH(4), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .A(as), .B(bs), .in_valid(vs),
    .R(rs), .Cout(cs), .R_q(rqs), .Cout_q(cqs), .out_valid(ovs),
    .op_cnt(opcs), .carry_cnt(ccs)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // WIDTH=1 exhaustive, clock idle and reset asserted
    a1 = 1'b0; b1 = 1'b0; #0.01;
    check("w1_00_r", 32'(r1), 32'd0); check("w1_00_c", 32'(c1), 32'd0);
    a1 = 1'b0; b1 = 1'b1; #0.01;
    check("w1_01_r", 32'(r1), 32'd1); check("w1_01_c", 32'(c1), 32'd0);
    a1 = 1'b1; b1 = 1'b0; #0.01;
    check("w1_10_r", 32'(r1), 32'd1); check("w1_10_c", 32'(c1), 32'd0);
    a1 = 1'b1; b1 = 1'b1; #0.01;
    check("w1_11_r", 32'(r1), 32'd0); check("w1_11_c", 32'(c1), 32'd1);

    // Registered stage cleared under reset, combinational path unaffected
    check("rst_rq1", 32'(rq1), 32'd0);
    check("rst_cq1", 32'(cq1), 32'd0);
    check("rst_ov1", 32'(ov1), 32'd0);

    // Start clock, release reset on a falling edge
    #1; clk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Pipeline WIDTH=4: 9+8
    v4 = 1'b1; a4 = 4'd9; b4 = 4'd8; #1;
    check("p_r", 32'(r4), 32'd1); check("p_c", 32'(c4), 32'd1);
    check("p_ov_before", 32'(ov4), 32'd0);
    @(posedge clk); #1;
    check("p_rq", 32'(rq4), 32'd1); check("p_cq", 32'(cq4), 32'd1);
    check("p_ov", 32'(ov4), 32'd1);

    // Hold: in_valid=0, 3+4
    @(negedge clk);
    v4 = 1'b0; a4 = 4'd3; b4 = 4'd4; #1;
    check("h_r", 32'(r4), 32'd7); check("h_c", 32'(c4), 32'd0);
    @(posedge clk); #1;
    check("h_rq", 32'(rq4), 32'd1); check("h_cq", 32'(cq4), 32'd1);
    check("h_ov", 32'(ov4), 32'd0);

    // New capture 7+5 = 12, no carry
    @(negedge clk);
    v4 = 1'b1; a4 = 4'd7; b4 = 4'd5;
    @(posedge clk); #1;
    check("c2_rq", 32'(rq4), 32'd12); check("c2_cq", 32'(cq4), 32'd0);
    check("c2_ov", 32'(ov4), 32'd1);

    // Mid-cycle async reset with capture pending
    a4 = 4'd15; b4 = 4'd15; #1;
    rst_n = 1'b0; #1;
    check("mr_rq", 32'(rq4), 32'd0); check("mr_cq", 32'(cq4), 32'd0);
    check("mr_ov", 32'(ov4), 32'd0);
    check("mr_r", 32'(r4), 32'd14); check("mr_c", 32'(c4), 32'd1);
    @(posedge clk); #1;
    check("mr_hold_rq", 32'(rq4), 32'd0); check("mr_hold_ov", 32'(ov4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rq", 32'(rq4), 32'd14); check("rel_cq", 32'(cq4), 32'd1);
    check("rel_ov", 32'(ov4), 32'd1);
    @(negedge clk);
    v4 = 1'b0;

    // Boundary WIDTH=8
    a8 = 8'd255; b8 = 8'd255; #1;
    check("b_ff_r", 32'(r8), 32'd254); check("b_ff_c", 32'(c8), 32'd1);
    a8 = 8'd0; b8 = 8'd0; #1;
    check("b_00_r", 32'(r8), 32'd0); check("b_00_c", 32'(c8), 32'd0);
    a8 = 8'd200; b8 = 8'd100; v8 = 1'b1; #1;
    check("b_300_r", 32'(r8), 32'd44); check("b_300_c", 32'(c8), 32'd1);
    @(posedge clk); #1;
    check("b_rq", 32'(rq8), 32'd44); check("b_cq", 32'(cq8), 32'd1);
    @(negedge clk);
    v8 = 1'b0;

`ifdef MEIO_SOMADOR_STATS_EN
    // Stats: 5 valid ops, carries on ops 1, 3, 5; CNT_W=2 saturates at 3
    check("s_init_op", 32'(opcs), 32'd0);
    vs = 1'b1; as = 4'd9;  bs = 4'd8;  @(negedge clk);
    as = 4'd1;  bs = 4'd2;  @(negedge clk);
    #1;
    check("s_op2", 32'(opcs), 32'd2); check("s_cc2", 32'(ccs), 32'd1);
    as = 4'd15; bs = 4'd1;  @(negedge clk);
    as = 4'd3;  bs = 4'd3;  @(negedge clk);
    as = 4'd8;  bs = 4'd8;  @(negedge clk);
    vs = 1'b0; #1;
    check("s_op_sat", 32'(opcs), 32'd3); check("s_cc", 32'(ccs), 32'd3);
    rst_n = 1'b0; #1;
    check("s_rst_op", 32'(opcs), 32'd0); check("s_rst_cc", 32'(ccs), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
